// File: rtl/msrv32_imm_encoder_pkg.sv
// Shared definitions for the immediate encoder: instruction-format selector codes.
package msrv32_imm_encoder_pkg;

    // Codes 3'b001 and 3'b111 are not listed; they fall back to the I format.
    typedef enum logic [2:0] {
        IMM_I   = 3'b000,
        IMM_S   = 3'b010,
        IMM_B   = 3'b011,
        IMM_U   = 3'b100,
        IMM_J   = 3'b101,
        IMM_CSR = 3'b110
    } imm_type_e;

    localparam int unsigned INSTR_W = 32;

    function automatic logic all_equal_21(input logic [20:0] bits);
        return (&bits) | (~|bits);
    endfunction

    function automatic logic all_equal_20(input logic [19:0] bits);
        return (&bits) | (~|bits);
    endfunction

    function automatic logic all_equal_12(input logic [11:0] bits);
        return (&bits) | (~|bits);
    endfunction

endpackage

// File: rtl/msrv32_imm_encoder_if.sv
// Request/response bundle of the immediate encoder; the slave side is the encoder itself.
interface msrv32_imm_encoder_if #(
    parameter int unsigned CNT_W = 16
);
    logic             valid_in;
    logic             ready_in;
    logic [31:0]      base_instr_in;
    logic [31:0]      imm_in;
    logic [2:0]       imm_type_in;
    logic             valid_out;
    logic             ready_out;
    logic [31:0]      instr_out;
    logic             err_out;
    logic             err_sticky_out;
    logic             err_clr_in;
    logic [CNT_W-1:0] count_out;

    modport master (
        output valid_in, base_instr_in, imm_in, imm_type_in, ready_out, err_clr_in,
        input  ready_in, valid_out, instr_out, err_out, err_sticky_out, count_out
    );

    modport slave (
        input  valid_in, base_instr_in, imm_in, imm_type_in, ready_out, err_clr_in,
        output ready_in, valid_out, instr_out, err_out, err_sticky_out, count_out
    );
endinterface

// File: rtl/msrv32_imm_pack.sv
// Combinational packer: scatters an immediate into its instruction-format bit fields
// and flags values that the selected format cannot represent.
module msrv32_imm_pack
    import msrv32_imm_encoder_pkg::*;
(
    input  logic [31:0] base_instr,
    input  logic [31:0] imm,
    input  logic [2:0]  imm_type,
    output logic [31:0] instr,
    output logic        range_err
);

    always_comb begin
        instr     = base_instr;
        range_err = 1'b0;
        case (imm_type)
            IMM_S: begin
                instr[31:25] = imm[11:5];
                instr[11:7]  = imm[4:0];
                range_err    = ~all_equal_21(imm[31:11]);
            end
            IMM_B: begin
                instr[31]    = imm[12];
                instr[30:25] = imm[10:5];
                instr[11:8]  = imm[4:1];
                instr[7]     = imm[11];
                range_err    = imm[0] | ~all_equal_20(imm[31:12]);
            end
            IMM_U: begin
                instr[31:12] = imm[31:12];
                range_err    = |imm[11:0];
            end
            IMM_J: begin
                instr[31]    = imm[20];
                instr[30:21] = imm[10:1];
                instr[20]    = imm[11];
                instr[19:12] = imm[19:12];
                range_err    = imm[0] | ~all_equal_12(imm[31:20]);
            end
            IMM_CSR: begin
                // Only the zimm field is written; rs1 position carries the 5-bit immediate.
                instr[19:15] = imm[4:0];
                range_err    = |imm[31:5];
            end
            default: begin
                instr[31:20] = imm[11:0];
                range_err    = ~all_equal_21(imm[31:11]);
            end
        endcase
    end

endmodule

// File: rtl/msrv32_imm_encoder.sv
// Immediate encoder: packs requests into instruction words, queues them in a small FIFO,
// and keeps a sticky range-error flag and a saturating accept counter.
module msrv32_imm_encoder
    import msrv32_imm_encoder_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             ms_riscv32_mp_clk_in,
    input  logic             ms_riscv32_mp_rst_in,
    msrv32_imm_encoder_if.slave bus
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [31:0]      word_mem [DEPTH];
    logic             err_mem  [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occupancy;
    logic             err_sticky;
    logic [CNT_W-1:0] accept_count;

    logic [31:0]      packed_word;
    logic             packed_err;
    logic             push;
    logic             pop;
    logic             not_full;
    logic             not_empty;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + PTR_W'(1);
    endfunction

    msrv32_imm_pack u_pack (
        .base_instr (bus.base_instr_in),
        .imm        (bus.imm_in),
        .imm_type   (bus.imm_type_in),
        .instr      (packed_word),
        .range_err  (packed_err)
    );

    // Space is judged from registered occupancy only, so a same-cycle pop never admits a push.
    assign not_full  = occupancy < OCC_W'(DEPTH);
    assign not_empty = occupancy != '0;
    assign push      = bus.valid_in & not_full;
    assign pop       = not_empty & bus.ready_out;

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (push) begin
            word_mem[wr_ptr] <= packed_word;
            err_mem[wr_ptr]  <= packed_err;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                occupancy <= occupancy + OCC_W'(1);
            end else if (pop && !push) begin
                occupancy <= occupancy - OCC_W'(1);
            end
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            err_sticky   <= 1'b0;
            accept_count <= '0;
        end else begin
            if (push && packed_err) begin
                err_sticky <= 1'b1;
            end else if (bus.err_clr_in) begin
                err_sticky <= 1'b0;
            end
            if (push && (accept_count != {CNT_W{1'b1}})) begin
                accept_count <= accept_count + CNT_W'(1);
            end
        end
    end

    // Storage is not reset; masking with occupancy keeps the outputs zero when empty.
    assign bus.ready_in       = not_full;
    assign bus.valid_out      = not_empty;
    assign bus.instr_out      = not_empty ? word_mem[rd_ptr] : 32'h0;
    assign bus.err_out        = not_empty & err_mem[rd_ptr];
    assign bus.err_sticky_out = err_sticky;
    assign bus.count_out      = accept_count;

endmodule
